// File: rtl/sparc_mem_pkg.sv
// Shared definitions for the byte-addressed SPARC memory: access size
// encodings, the request FSM states, and the helpers that turn a size into
// a byte count and flag misaligned / out-of-range / illegal accesses.
package sparc_mem_pkg;

    // Width of the latency down-counter (LATENCY is 1..4, so 0..3 fits).
    localparam int CNT_W = 2;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } size_t;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Number of bytes touched by an access of the given size; 0 for the
    // illegal encoding so callers cannot accidentally use it as a length.
    function automatic int unsigned size_bytes(input logic [1:0] size);
        int unsigned n;
        case (size)
            SZ_BYTE: n = 1;
            SZ_HALF: n = 2;
            SZ_WORD: n = 4;
            default: n = 0;
        endcase
        return n;
    endfunction

    // Returns 1 when the access must be answered with an error: illegal
    // size, natural-alignment violation, or the last byte past the array.
    function automatic logic access_err(input logic [1:0]  size,
                                        input int unsigned addr,
                                        input int unsigned depth);
        logic        e;
        int unsigned n;
        n = size_bytes(size);
        case (size)
            SZ_HALF: e = addr[0];
            SZ_WORD: e = |addr[1:0];
            SZ_ILL:  e = 1'b1;
            default: e = 1'b0;
        endcase
        if ((n != 0) && ((addr + n - 1) >= depth)) begin
            e = 1'b1;
        end
        return e;
    endfunction

endpackage

// File: rtl/sparc_mem_loader.sv
// Byte-serial preload engine: walks a pointer through the array one byte
// per load strobe and latches "full" once every location has been written.
// After that, strobes are ignored until the next reset.
module sparc_mem_loader #(
    parameter int DEPTH  = 512,
    parameter int ADDR_W = 9
) (
    input  logic              i_clk,
    input  logic              i_clr,
    input  logic              i_load_en,
    output logic              o_wr_en,
    output logic [ADDR_W-1:0] o_wr_addr,
    output logic              o_full
);

    logic [ADDR_W-1:0] r_ptr;
    logic              r_full;

    // A load byte is written only while not full and not in reset, so a
    // strobe held across reset never disturbs the array.
    assign o_wr_en   = i_load_en & ~r_full & i_clr;
    assign o_wr_addr = r_ptr;
    assign o_full    = r_full;

    // Advance the pointer per written byte; the wrap back to 0 marks full.
    always_ff @(posedge i_clk) begin
        if (!i_clr) begin
            r_ptr  <= '0;
            r_full <= 1'b0;
        end else if (o_wr_en) begin
            r_ptr <= r_ptr + ADDR_W'(1);
            if (r_ptr == ADDR_W'(DEPTH - 1)) begin
                r_full <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/sparc_byte_mem.sv
// Byte-addressed, big-endian memory serving byte/halfword/word reads and
// writes through a single-outstanding request port with fixed latency.
// A serial preload port fills the array from the bench or boot logic.
module sparc_byte_mem
    import sparc_mem_pkg::*;
#(
    parameter int DEPTH   = 512,
    parameter int ADDR_W  = 9,
    parameter int LATENCY = 1
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              load_en,
    input  logic [7:0]        load_data,
    output logic              load_full,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic              req_we,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_data,
    output logic              rsp_err,
    output state_t            dbg_state
);

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

    // Storage; deliberately has no reset so preloaded code survives clr.
    logic [7:0]        r_mem [DEPTH];

    // Request FSM and captured request fields.
    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic [1:0]        r_size;
    logic              r_signed;
    logic              r_we;
    logic              r_err;

    // Registered response.
    logic              r_rsp_valid;
    logic [31:0]       r_rsp_data;
    logic              r_rsp_err;

    // Preload write port.
    logic              w_load_we;
    logic [ADDR_W-1:0] w_load_addr;

    // Request-side combinational signals.
    logic              w_hs;
    logic              w_req_err;
    logic              w_wr_ok;
    logic              w_lane_we   [4];
    logic [ADDR_W-1:0] w_lane_addr [4];
    logic [7:0]        w_lane_data [4];
    logic [7:0]        w_rd_b      [4];
    logic [31:0]       w_rd_data;

    sparc_mem_loader #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_loader (
        .i_clk     (clk),
        .i_clr     (clr),
        .i_load_en (load_en),
        .o_wr_en   (w_load_we),
        .o_wr_addr (w_load_addr),
        .o_full    (load_full)
    );

    // Handshake: a request transfers on a rising edge where req_valid and
    // req_ready are both high. req_ready is high only in IDLE with no load
    // strobe present, so preload always wins, and only one request can be
    // outstanding. The requester must hold its fields stable while
    // req_valid is high and req_ready is low.
    assign req_ready = (r_state == IDLE) & ~load_en;
    assign w_hs      = req_valid & req_ready & clr;

    // Classify the incoming request and steer write bytes onto four lanes,
    // most-significant byte at the lowest address.
    always_comb begin
        w_req_err = access_err(req_size, 32'(req_addr), DEPTH);
        w_wr_ok   = w_hs & req_we & ~w_req_err;
        for (int i = 0; i < 4; i++) begin
            w_lane_we[i]   = 1'b0;
            w_lane_addr[i] = req_addr + ADDR_W'(i);
            w_lane_data[i] = 8'h00;
        end
        case (req_size)
            SZ_BYTE: begin
                w_lane_we[0]   = w_wr_ok;
                w_lane_data[0] = req_wdata[7:0];
            end
            SZ_HALF: begin
                w_lane_we[0]   = w_wr_ok;
                w_lane_we[1]   = w_wr_ok;
                w_lane_data[0] = req_wdata[15:8];
                w_lane_data[1] = req_wdata[7:0];
            end
            SZ_WORD: begin
                for (int i = 0; i < 4; i++) begin
                    w_lane_we[i] = w_wr_ok;
                end
                w_lane_data[0] = req_wdata[31:24];
                w_lane_data[1] = req_wdata[23:16];
                w_lane_data[2] = req_wdata[15:8];
                w_lane_data[3] = req_wdata[7:0];
            end
            default: begin
                for (int i = 0; i < 4; i++) begin
                    w_lane_we[i] = 1'b0;
                end
            end
        endcase
    end

    // Array writes: preload byte and request lanes never coincide because
    // a request is only accepted while load_en is low.
    always_ff @(posedge clk) begin
        if (w_load_we) begin
            r_mem[w_load_addr] <= load_data;
        end
        for (int i = 0; i < 4; i++) begin
            if (w_lane_we[i]) begin
                r_mem[w_lane_addr[i]] <= w_lane_data[i];
            end
        end
    end

    // Read the four bytes starting at the captured address; the address
    // wraps inside the array, which only matters for errored requests
    // whose data is discarded anyway.
    for (genvar g = 0; g < 4; g++) begin : g_rd
        assign w_rd_b[g] = r_mem[r_addr + ADDR_W'(g)];
    end

    // Right-align and extend the read data; writes and errors return 0.
    always_comb begin
        case (r_size)
            SZ_BYTE: w_rd_data = {{24{r_signed & w_rd_b[0][7]}}, w_rd_b[0]};
            SZ_HALF: w_rd_data = {{16{r_signed & w_rd_b[0][7]}}, w_rd_b[0], w_rd_b[1]};
            SZ_WORD: w_rd_data = {w_rd_b[0], w_rd_b[1], w_rd_b[2], w_rd_b[3]};
            default: w_rd_data = 32'h0;
        endcase
        if (r_we | r_err) begin
            w_rd_data = 32'h0;
        end
    end

    // Request FSM: capture on handshake, count down the latency, then emit
    // a one-cycle response built from the array contents at that moment.
    always_ff @(posedge clk) begin
        if (!clr) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_addr      <= '0;
            r_size      <= 2'b00;
            r_signed    <= 1'b0;
            r_we        <= 1'b0;
            r_err       <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= 32'h0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= 32'h0;
            r_rsp_err   <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_hs) begin
                        r_addr   <= req_addr;
                        r_size   <= req_size;
                        r_signed <= req_signed;
                        r_we     <= req_we;
                        r_err    <= w_req_err;
                        r_cnt    <= CNT_INIT;
                        r_state  <= BUSY;
                    end
                end
                BUSY: begin
                    if (r_cnt == '0) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= r_err;
                        r_rsp_data  <= w_rd_data;
                        r_state     <= IDLE;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign rsp_err   = r_rsp_err;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_sparc_byte_mem.sv
// Bench for sparc_byte_mem: two instances (LATENCY 1 and 3) share a clock.
// Expected responses come from a byte-array model that applies the access
// rules arithmetically.
module tb_sparc_byte_mem;
    import sparc_mem_pkg::*;

    localparam int DEPTH = 512;
    localparam int AW    = 9;

    logic        clk;
    logic        clr        [2];
    logic        load_en    [2];
    logic [7:0]  load_data  [2];
    logic        load_full  [2];
    logic        req_valid  [2];
    logic        req_ready  [2];
    logic [AW-1:0] req_addr [2];
    logic [1:0]  req_size   [2];
    logic        req_signed [2];
    logic        req_we     [2];
    logic [31:0] req_wdata  [2];
    logic        rsp_valid  [2];
    logic [31:0] rsp_data   [2];
    logic        rsp_err    [2];
    state_t      dbg_state  [2];

    int n_tests;
    int n_fail;

    // Reference model: byte image plus preload pointer per instance.
    logic [7:0] mdl   [2][DEPTH];
    int         mptr  [2];
    bit         mfull [2];

    logic [7:0] init_b [8];

    sparc_byte_mem #(.DEPTH(DEPTH), .ADDR_W(AW), .LATENCY(1)) u_dut0 (
        .clk(clk), .clr(clr[0]), .load_en(load_en[0]), .load_data(load_data[0]),
        .load_full(load_full[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_addr(req_addr[0]), .req_size(req_size[0]), .req_signed(req_signed[0]),
        .req_we(req_we[0]), .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]),
        .rsp_data(rsp_data[0]), .rsp_err(rsp_err[0]), .dbg_state(dbg_state[0])
    );

    sparc_byte_mem #(.DEPTH(DEPTH), .ADDR_W(AW), .LATENCY(3)) u_dut1 (
        .clk(clk), .clr(clr[1]), .load_en(load_en[1]), .load_data(load_data[1]),
        .load_full(load_full[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_addr(req_addr[1]), .req_size(req_size[1]), .req_signed(req_signed[1]),
        .req_we(req_we[1]), .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]),
        .rsp_data(rsp_data[1]), .rsp_err(rsp_err[1]), .dbg_state(dbg_state[1])
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic void model_load(input int d, input logic [7:0] b);
        if (!mfull[d]) begin
            mdl[d][mptr[d]] = b;
            mptr[d]++;
            if (mptr[d] == DEPTH) begin
                mptr[d]  = 0;
                mfull[d] = 1'b1;
            end
        end
    endfunction

    // Applies one accepted access to the model and returns the response
    // it must produce.
    function automatic void model_access(input int d, input int addr, input int size,
                                         input bit sgn, input bit we, input logic [31:0] wd,
                                         output logic [31:0] ed, output logic ee);
        int     n;
        longint v;
        n  = (size == 0) ? 1 : (size == 1) ? 2 : (size == 2) ? 4 : 0;
        ed = 32'h0;
        if (n == 0) ee = 1'b1;
        else        ee = ((addr % n) != 0) || ((addr + n) > DEPTH);
        if (ee) return;
        if (we) begin
            for (int i = 0; i < n; i++) begin
                mdl[d][addr + i] = 8'(wd >> (8 * (n - 1 - i)));
            end
            return;
        end
        v = 0;
        for (int i = 0; i < n; i++) begin
            v = v * 256 + longint'(mdl[d][addr + i]);
        end
        if (sgn && (n < 4) && (v >= (longint'(1) << (8 * n - 1)))) begin
            v = v - (longint'(1) << (8 * n));
        end
        ed = 32'(v);
    endfunction

    // Drive one request, wait (bounded) for its response, check handshake
    // timing, and hand back both the observed and the modelled response.
    task automatic do_req(input int d, input int addr, input int size, input bit sgn,
                          input bit we, input logic [31:0] wd,
                          output logic [31:0] od, output logic oe,
                          output logic [31:0] ed, output logic ee);
        int lat;
        int lat_seen;
        bit busy_ready;
        bit seen;
        lat = (d == 0) ? 1 : 3;
        @(negedge clk);
        req_valid[d]  = 1'b1;
        req_addr[d]   = AW'(addr);
        req_size[d]   = 2'(size);
        req_signed[d] = sgn;
        req_we[d]     = we;
        req_wdata[d]  = wd;
        #1;
        check($sformatf("ready_idle_d%0d", d), 32'(req_ready[d]), 32'd1);
        @(posedge clk);
        model_access(d, addr, size, sgn, we, wd, ed, ee);
        #1;
        req_valid[d] = 1'b0;
        busy_ready = req_ready[d];
        seen       = 1'b0;
        lat_seen   = -1;
        od         = 32'h0;
        oe         = 1'b0;
        for (int k = 1; k <= lat + 4 && !seen; k++) begin
            @(posedge clk);
            #1;
            if (rsp_valid[d]) begin
                seen     = 1'b1;
                lat_seen = k;
                od       = rsp_data[d];
                oe       = rsp_err[d];
            end else if (req_ready[d]) begin
                busy_ready = 1'b1;
            end
        end
        check($sformatf("busy_ready_d%0d", d), 32'(busy_ready), 32'd0);
        check($sformatf("latency_d%0d", d), 32'(lat_seen), 32'(lat));
    endtask

    task automatic dir_req(input int d, input string tag, input int addr, input int size,
                           input bit sgn, input bit we, input logic [31:0] wd,
                           input logic [31:0] xd, input logic xe);
        logic [31:0] od, ed;
        logic        oe, ee;
        do_req(d, addr, size, sgn, we, wd, od, oe, ed, ee);
        check({tag, "_data"}, od, xd);
        check({tag, "_err"}, 32'(oe), 32'(xe));
    endtask

    task automatic rnd_req(input int d, input int count);
        logic [31:0] od, ed, wd;
        logic        oe, ee;
        int          sz, a;
        bit          s, w;
        for (int t = 0; t < count; t++) begin
            sz = int'($urandom_range(0, 3));
            a  = int'($urandom_range(0, DEPTH - 1));
            if (sz < 3 && $urandom_range(0, 3) != 0) a = a & ~((1 << sz) - 1);
            if ($urandom_range(0, 7) == 0) a = DEPTH - 1 - int'($urandom_range(0, 4));
            s  = 1'($urandom_range(0, 1));
            w  = ($urandom_range(0, 2) == 0);
            wd = $urandom;
            do_req(d, a, sz, s, w, wd, od, oe, ed, ee);
            check($sformatf("rnd_data_d%0d", d), od, ed);
            check($sformatf("rnd_err_d%0d", d), 32'(oe), 32'(ee));
        end
    endtask

    // Accept a request, then pull clr low the very next cycle: the request
    // must vanish without a response while the array is left intact.
    task automatic reset_mid(input bit we, input int addr, input logic [31:0] wd);
        logic [31:0] ed;
        logic        ee;
        bit          saw;
        @(negedge clk);
        req_valid[0] = 1'b1;
        req_addr[0]  = AW'(addr);
        req_size[0]  = 2'(SZ_WORD);
        req_signed[0] = 1'b0;
        req_we[0]    = we;
        req_wdata[0] = wd;
        @(posedge clk);
        model_access(0, addr, 2, 1'b0, we, wd, ed, ee);
        #1;
        req_valid[0] = 1'b0;
        check("state_busy", 32'(dbg_state[0]), 32'(BUSY));
        @(negedge clk);
        clr[0] = 1'b0;
        saw = 1'b0;
        @(posedge clk);
        #1;
        if (rsp_valid[0]) saw = 1'b1;
        @(negedge clk);
        clr[0] = 1'b1;
        mptr[0]  = 0;
        mfull[0] = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            if (rsp_valid[0]) saw = 1'b1;
        end
        check("rst_no_rsp", 32'(saw), 32'd0);
        check("rst_ready", 32'(req_ready[0]), 32'd1);
        check("rst_full", 32'(load_full[0]), 32'd0);
        check("rst_state", 32'(dbg_state[0]), 32'(IDLE));
    endtask

    initial begin
        logic [7:0] b;
        bit saw_ready;
        bit saw_rsp;
        n_tests = 0;
        n_fail  = 0;
        init_b = '{8'h81, 8'hC3, 8'hE0, 8'h08, 8'h01, 8'h00, 8'h00, 8'h00};
        for (int d = 0; d < 2; d++) begin
            clr[d] = 1'b0; load_en[d] = 1'b0; load_data[d] = 8'h00;
            req_valid[d] = 1'b0; req_addr[d] = '0; req_size[d] = 2'b00;
            req_signed[d] = 1'b0; req_we[d] = 1'b0; req_wdata[d] = 32'h0;
            mptr[d] = 0; mfull[d] = 1'b0;
        end

        // Reset
        repeat (3) @(posedge clk);
        @(negedge clk);
        clr[0] = 1'b1;
        clr[1] = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("rst_ready_d%0d", d), 32'(req_ready[d]), 32'd1);
            check($sformatf("rst_full_d%0d", d), 32'(load_full[d]), 32'd0);
            check($sformatf("rst_rsp_valid_d%0d", d), 32'(rsp_valid[d]), 32'd0);
            check($sformatf("rst_rsp_data_d%0d", d), rsp_data[d], 32'h0);
            check($sformatf("rst_rsp_err_d%0d", d), 32'(rsp_err[d]), 32'd0);
            check($sformatf("rst_state_d%0d", d), 32'(dbg_state[d]), 32'(IDLE));
        end

        // Preload both instances while DUT0 also holds a pending request
        saw_ready = 1'b0;
        saw_rsp   = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            b = (i < 8) ? init_b[i] : 8'($urandom_range(0, 255));
            for (int d = 0; d < 2; d++) begin
                load_en[d]   = 1'b1;
                load_data[d] = b;
            end
            if (i == 0) begin
                req_valid[0] = 1'b1;
                req_addr[0]  = '0;
                req_size[0]  = 2'(SZ_WORD);
                req_we[0]    = 1'b1;
                req_wdata[0] = 32'hDEAD_BEEF;
            end
            #1;
            if (req_ready[0]) saw_ready = 1'b1;
            if (rsp_valid[0] || rsp_valid[1]) saw_rsp = 1'b1;
            if (i == DEPTH - 1) check("full_before_last", 32'(load_full[0]), 32'd0);
            @(posedge clk);
            for (int d = 0; d < 2; d++) model_load(d, b);
        end
        // One more strobe after full: must be ignored
        @(negedge clk);
        for (int d = 0; d < 2; d++) load_data[d] = 8'h55;
        #1;
        check("full_after_512_d0", 32'(load_full[0]), 32'd1);
        check("full_after_512_d1", 32'(load_full[1]), 32'd1);
        if (req_ready[0]) saw_ready = 1'b1;
        @(posedge clk);
        for (int d = 0; d < 2; d++) model_load(d, 8'h55);
        @(negedge clk);
        for (int d = 0; d < 2; d++) load_en[d] = 1'b0;
        req_valid[0] = 1'b0;
        req_we[0]    = 1'b0;
        #1;
        if (rsp_valid[0]) saw_rsp = 1'b1;
        check("load_blocks_ready", 32'(saw_ready), 32'd0);
        check("load_blocks_accept", 32'(saw_rsp), 32'd0);

        // Directed reads/writes on LATENCY=1
        dir_req(0, "word0",     0,   2, 1'b0, 1'b0, 32'h0, 32'h81C3_E008, 1'b0);
        dir_req(0, "byte1_s",   1,   0, 1'b1, 1'b0, 32'h0, 32'hFFFF_FFC3, 1'b0);
        dir_req(0, "byte1_u",   1,   0, 1'b0, 1'b0, 32'h0, 32'h0000_00C3, 1'b0);
        dir_req(0, "half4_s",   4,   1, 1'b1, 1'b0, 32'h0, 32'h0000_0100, 1'b0);
        dir_req(0, "word2_mis", 2,   2, 1'b0, 1'b0, 32'h0, 32'h0,         1'b1);
        dir_req(0, "word510",   510, 2, 1'b0, 1'b0, 32'h0, 32'h0,         1'b1);
        dir_req(0, "half511",   511, 1, 1'b0, 1'b0, 32'h0, 32'h0,         1'b1);
        dir_req(0, "size11",    0,   3, 1'b0, 1'b0, 32'h0, 32'h0,         1'b1);
        dir_req(0, "wr_word2",  2,   2, 1'b0, 1'b1, 32'hCAFE_F00D, 32'h0, 1'b1);
        dir_req(0, "wr_half6",  6,   1, 1'b0, 1'b1, 32'h1234_ABCD, 32'h0, 1'b0);
        dir_req(0, "word4",     4,   2, 1'b0, 1'b0, 32'h0, 32'h0100_ABCD, 1'b0);
        dir_req(0, "word0_again", 0, 2, 1'b0, 1'b0, 32'h0, 32'h81C3_E008, 1'b0);
        dir_req(0, "wr_byte511", 511, 0, 1'b0, 1'b1, 32'h0000_00A7, 32'h0, 1'b0);
        dir_req(0, "byte511_s", 511, 0, 1'b1, 1'b0, 32'h0, 32'hFFFF_FFA7, 1'b0);

        // LATENCY=3 instance
        dir_req(1, "l3_word0",  0,   2, 1'b0, 1'b0, 32'h0, 32'h81C3_E008, 1'b0);
        dir_req(1, "l3_word2",  2,   2, 1'b0, 1'b0, 32'h0, 32'h0,         1'b1);

        // Randomized traffic against the model
        rnd_req(0, 120);
        rnd_req(1, 30);

        // Reset in the middle of a read, then of a write
        reset_mid(1'b0, 0, 32'h0);
        dir_req(0, "post_rst_word0", 0, 2, 1'b0, 1'b0, 32'h0, 32'h81C3_E008, 1'b0);
        @(negedge clk);
        load_en[0]   = 1'b1;
        load_data[0] = 8'hA5;
        @(posedge clk);
        model_load(0, 8'hA5);
        @(negedge clk);
        load_en[0] = 1'b0;
        dir_req(0, "reload_byte0", 0, 0, 1'b0, 1'b0, 32'h0, 32'h0000_00A5, 1'b0);
        reset_mid(1'b1, 8, 32'hDEAD_BEEF);
        dir_req(0, "wr_survives_rst", 8, 2, 1'b0, 1'b0, 32'h0, 32'hDEAD_BEEF, 1'b0);
        rnd_req(0, 20);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sparc_byte_mem.md
Name: sparc_byte_mem

Overview:
Parametrised successor to the fixed 512x8 instruction ROM. It is a byte-addressed, big-endian memory with byte, halfword and word access, optional sign extension, and writes. A byte-serial preload port replaces file-driven loading in benches. Requests use a valid/ready handshake with a configurable read latency, so one block serves as both instruction memory and data memory for the SPARC pipeline.

Parameters:
DEPTH, 512, memory size in bytes; power of two, 64..4096
ADDR_W, 9, address width; equals log2(DEPTH)
LATENCY, 1, cycles from request acceptance to response; legal range 1..4

Ports:
clk  in  1  clock; all state updates on the rising edge
clr  in  1  reset; synchronous, active-low
load_en  in  1  preload strobe; writes load_data at the load pointer
load_data  in  8  preload byte
load_full  out  1  high once DEPTH bytes have been preloaded
req_valid  in  1  request present
req_ready  out  1  block can accept a request this cycle
req_addr  in  ADDR_W  byte address of the most-significant byte
req_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal
req_signed  in  1  sign-extend byte/halfword reads
req_we  in  1  1 = write, 0 = read
req_wdata  in  32  write data; right-aligned for byte and halfword
rsp_valid  out  1  one-cycle response pulse
rsp_data  out  32  read data, right-aligned; 0 on writes and errors
rsp_err  out  1  qualifies rsp_valid: misaligned, out-of-range or illegal size

Behaviour:
- Reset (clr=0 at a clock edge):
  - State goes to IDLE; load pointer = 0; load_full = 0.
  - rsp_valid, rsp_err and rsp_data go to 0; the latency counter is cleared.
  - Memory array is NOT cleared.
  - Reset mid-request drops the request; no response is ever issued for it.
  - A write accepted before the reset stays committed.
- States: IDLE, BUSY.
  - IDLE: req_ready = ~load_en. Handshake = req_valid & req_ready.
    - On handshake, capture addr/size/signed/we/wdata and move to BUSY.
  - BUSY: req_ready = 0. Counter runs LATENCY-1 down to 0.
    - Count 0: assert rsp_valid for one cycle and return to IDLE.
    - With LATENCY=1, the response appears on the cycle after acceptance.
  - No back-to-back acceptance: throughput is one request per LATENCY+1 cycles.
- Preload:
  - Each cycle with load_en=1 and load_full=0 writes Mem[ptr]=load_data and increments ptr.
  - When ptr wraps from DEPTH-1 to 0, load_full is set and further load_en is ignored.
  - load_en=1 forces req_ready=0, so load has priority over requests.
  - load_en while BUSY still writes; the in-flight response uses the memory contents at the response cycle.
- Endianness:
  - Word at address A = {Mem[A],Mem[A+1],Mem[A+2],Mem[A+3]}.
  - Halfword = {Mem[A],Mem[A+1]}.
- Alignment: halfword requires A[0]=0; word requires A[1:0]=00.
- Error cases:
  - Misaligned, req_size=11, or A+bytes-1 >= DEPTH give rsp_err=1, rsp_data=0, and no memory write.
  - The error response still follows the full LATENCY.
- Reads:
  - Data is sampled from the array on the response cycle.
  - Byte/halfword are zero-extended, or sign-extended when req_signed=1.
- Writes:
  - Committed on the acceptance cycle, big-endian, using req_wdata's low 8/16/32 bits.
  - Response has rsp_data=0 and rsp_err=0.
- Read-after-write: a read accepted the cycle after a write's response sees the new data.

Decomposition:
- Package sparc_mem_pkg holds:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD;
  - state enum IDLE/BUSY;
  - a function returning the byte count for a size;
  - a function computing the misaligned/out-of-range error.
- One sub-module, sparc_mem_loader: preload pointer, wrap, and load_full.
- The top holds the array, FSM, latency counter and response formatting.

Test Plan:
- Preload 0x81,0xC3,0xE0,0x08,0x01,0x00,0x00,0x00, then read word @0 with LATENCY=1 -> rsp_data=0x81C3E008 one cycle after acceptance, rsp_err=0.
- Read byte @1 with req_signed=1 -> 0xFFFFFFC3; same with req_signed=0 -> 0x000000C3; read halfword @4 signed -> 0x00000100.
- Read word @2 -> rsp_err=1, rsp_data=0; read word @DEPTH-2 (510) -> rsp_err=1; memory unchanged.
- Write halfword 0x1234ABCD @6, then read word @4 -> 0x0100ABCD; with LATENCY=3, rsp_valid rises exactly 3 cycles after acceptance and req_ready=0 throughout.
- Hold load_en=1 and req_valid=1 together -> req_ready=0 and no acceptance; after 512 load bytes load_full=1, and a further load_en leaves Mem[0] unchanged.
- Accept a read, drive clr=0 in the next cycle -> rsp_valid never pulses, req_ready=1 after reset, load_full=0, preloaded data still readable.
